dm_run_scheduler: RTL and testbench
===================================

DM_RUN_SCHEDULER -- requirements
Module: dm_run_scheduler

Interface
REQ-001 The block SHALL have parameter CNT_BIT, default 31, width of all transfer counts.
REQ-002 The block SHALL have parameter AWIDTH, default 21, width of the chunk base address.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port i_run, input, 1, start request; sampled only in S_IDLE.
REQ-006 The block SHALL have port i_total_cnt, input, CNT_BIT, total words to move; sampled with i_run.
REQ-007 The block SHALL have port i_chunk_cnt, input, CNT_BIT, maximum words per mover run; sampled with i_run.
REQ-008 The block SHALL have port o_idle, output, 1, high only in S_IDLE.
REQ-009 The block SHALL have port o_busy, output, 1, high in every state except S_IDLE.
REQ-010 The block SHALL have port o_done, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port o_chunks_done, output, CNT_BIT, number of chunks completed in the current job.
REQ-012 The block SHALL have port o_dm_run, output, 1, one-cycle start pulse to data_mover_bram i_run.
REQ-013 The block SHALL have port o_dm_num_cnt, output, CNT_BIT, word count for the issued run; registered.
REQ-014 The block SHALL have port o_dm_base, output, AWIDTH, start address of the issued chunk; registered.
REQ-015 The block SHALL have port i_dm_idle, input, 1, data_mover_bram o_idle.
REQ-016 The block SHALL have port i_dm_done, input, 1, data_mover_bram o_done; level or pulse tolerated.

Function
REQ-017 The FSM SHALL have states S_IDLE, S_WAIT_IDLE, S_ISSUE, S_WAIT_DONE and S_DONE, one-hot or binary.
REQ-018 In S_IDLE with i_run=1, the block SHALL latch the job and enter S_WAIT_IDLE, or S_DONE if i_total_cnt=0: remaining=i_total_cnt; chunk=i_chunk_cnt, or i_total_cnt if i_chunk_cnt=0; base=0; o_chunks_done=0.
REQ-019 i_run outside S_IDLE SHALL be ignored.
REQ-020 In S_WAIT_IDLE, the block SHALL move to S_ISSUE on the first cycle with i_dm_idle=1; o_dm_num_cnt=min(remaining, chunk); o_dm_base=base[AWIDTH-1:0].
REQ-021 In S_ISSUE, o_dm_run SHALL be high for exactly that one cycle, and the next state SHALL be S_WAIT_DONE with accepted flag=0.
REQ-022 In S_WAIT_DONE, accepted SHALL set on the first cycle with i_dm_idle=0; i_dm_done SHALL be ignored while accepted=0, so a stale done level from the previous run is discarded.
REQ-023 In S_WAIT_DONE, when accepted=1 and i_dm_done=1: remaining-=o_dm_num_cnt; base+=o_dm_num_cnt, wrapping modulo 2^AWIDTH; o_chunks_done+=1; next state S_DONE if the new remaining=0, else S_WAIT_IDLE.
REQ-024 In S_DONE, o_done SHALL be high for exactly one cycle, and the next state SHALL be S_IDLE.
REQ-025 o_dm_num_cnt, o_dm_base and o_chunks_done SHALL hold until the next update or the next job start.
REQ-026 The final chunk SHALL carry the remainder (total mod chunk) when nonzero; no run SHALL ever be issued with count 0.
REQ-027 A job SHALL issue exactly ceil(total/chunk) runs.
REQ-028 o_idle and i_run high in the same cycle SHALL start the job with no lost pulse; job start-to-first-o_dm_run SHALL take 2 cycles when i_dm_idle=1.

Reset
REQ-029 While reset_n=0, the FSM SHALL be in S_IDLE; o_idle=1; o_busy=0; o_done=0; o_dm_run=0; o_dm_num_cnt=0; o_dm_base=0; o_chunks_done=0; internal remaining/chunk/base/accepted=0.
REQ-030 Reset asserted mid-job SHALL abort immediately with no further o_dm_run; the job is discarded after reset release.

Verification
REQ-031 total=8192, chunk=2048, mover model always ready -> exactly 4 o_dm_run pulses with bases 0/2048/4096/6144, each count 2048; one o_done; o_chunks_done=4.
REQ-032 total=5000, chunk=2048 -> counts 2048, 2048, 904; bases 0, 2048, 4096; o_chunks_done=3.
REQ-033 total=0 -> no o_dm_run; o_done pulse 2 cycles after i_run; chunk=0, total=100 -> single run with count 100.
REQ-034 Mover model holds o_done high until next i_run and delays idle drop by 3 cycles -> no premature chunk advance; the run sequence matches REQ-031.
REQ-035 i_run pulsed during S_WAIT_DONE -> ignored, no extra runs; reset_n low mid-job -> all outputs at reset values; after release, o_idle=1 with no o_dm_run.
REQ-036 Back-to-back job: i_run asserted the cycle after o_done -> new job starts; o_chunks_done resets to 0.

Source files
------------

// File: rtl/dm_run_scheduler_if.sv
// Scheduler <-> data mover link: run request with count/base, idle/done status back.
interface dm_run_scheduler_if #(
   parameter int unsigned CNT_BIT = 31,
   parameter int unsigned AWIDTH  = 21
);
   logic               o_dm_run;
   logic [CNT_BIT-1:0] o_dm_num_cnt;
   logic [AWIDTH-1:0]  o_dm_base;
   logic               i_dm_idle;
   logic               i_dm_done;

   // Scheduler side
   modport master (
      output o_dm_run,
      output o_dm_num_cnt,
      output o_dm_base,
      input  i_dm_idle,
      input  i_dm_done
   );

   // Data mover side
   modport slave (
      input  o_dm_run,
      input  o_dm_num_cnt,
      input  o_dm_base,
      output i_dm_idle,
      output i_dm_done
   );
endinterface

// File: rtl/dm_run_scheduler.sv
// Splits one transfer job into chunk-sized data mover runs, issuing them one at a time.
module dm_run_scheduler #(
   parameter int unsigned CNT_BIT = 31,
   parameter int unsigned AWIDTH  = 21
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_run,
   input  logic [CNT_BIT-1:0] i_total_cnt,
   input  logic [CNT_BIT-1:0] i_chunk_cnt,
   output logic               o_idle,
   output logic               o_busy,
   output logic               o_done,
   output logic [CNT_BIT-1:0] o_chunks_done,
   dm_run_scheduler_if.master dm
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_IDLE,
      S_ISSUE,
      S_WAIT_DONE,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_BIT-1:0] remaining_q, remaining_d;
   logic [CNT_BIT-1:0] chunk_q, chunk_d;
   logic [AWIDTH-1:0]  base_q, base_d;
   logic               accepted_q, accepted_d;
   logic [CNT_BIT-1:0] num_q, num_d;
   logic [AWIDTH-1:0]  dm_base_q, dm_base_d;
   logic [CNT_BIT-1:0] chunks_done_q, chunks_done_d;
   logic [CNT_BIT-1:0] next_cnt;

   // Count for the next run: whatever is left, capped at the chunk size
   assign next_cnt = (remaining_q < chunk_q) ? remaining_q : chunk_q;

   // State and job registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         remaining_q   <= '0;
         chunk_q       <= '0;
         base_q        <= '0;
         accepted_q    <= 1'b0;
         num_q         <= '0;
         dm_base_q     <= '0;
         chunks_done_q <= '0;
      end else begin
         state_q       <= state_d;
         remaining_q   <= remaining_d;
         chunk_q       <= chunk_d;
         base_q        <= base_d;
         accepted_q    <= accepted_d;
         num_q         <= num_d;
         dm_base_q     <= dm_base_d;
         chunks_done_q <= chunks_done_d;
      end
   end

   // Next-state and job bookkeeping
   always_comb begin
      state_d       = state_q;
      remaining_d   = remaining_q;
      chunk_d       = chunk_q;
      base_d        = base_q;
      accepted_d    = accepted_q;
      num_d         = num_q;
      dm_base_d     = dm_base_q;
      chunks_done_d = chunks_done_q;
      case (state_q)
         S_IDLE: begin
            if (i_run) begin
               remaining_d   = i_total_cnt;
               // A zero chunk size means "do it all in one run"
               chunk_d       = (i_chunk_cnt == '0) ? i_total_cnt : i_chunk_cnt;
               base_d        = '0;
               chunks_done_d = '0;
               accepted_d    = 1'b0;
               state_d       = (i_total_cnt == '0) ? S_DONE : S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (dm.i_dm_idle) begin
               num_d     = next_cnt;
               dm_base_d = base_q;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            accepted_d = 1'b0;
            state_d    = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            // Until the mover has visibly gone busy, any done level is left over
            // from the previous run and must not advance the job.
            if (!accepted_q) begin
               if (!dm.i_dm_idle) begin
                  accepted_d = 1'b1;
               end
            end else if (dm.i_dm_done) begin
               remaining_d   = remaining_q - num_q;
               base_d        = base_q + AWIDTH'(num_q);
               chunks_done_d = chunks_done_q + CNT_BIT'(1);
               state_d       = (remaining_q == num_q) ? S_DONE : S_WAIT_IDLE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Status and mover request outputs
   always_comb begin
      o_idle          = (state_q == S_IDLE);
      o_busy          = (state_q != S_IDLE);
      o_done          = (state_q == S_DONE);
      o_chunks_done   = chunks_done_q;
      dm.o_dm_run     = (state_q == S_ISSUE);
      dm.o_dm_num_cnt = num_q;
      dm.o_dm_base    = dm_base_q;
   end

endmodule

// File: tb/tb_dm_run_scheduler.sv
// Bench for dm_run_scheduler: directed jobs, a data mover model, and a run/done scoreboard.
`timescale 1ns/1ps
module tb_dm_run_scheduler;
   localparam int CNT_BIT = 31;
   localparam int AWIDTH  = 21;

   typedef struct {
      int cnt;
      int base;
   } run_t;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               i_run = 1'b0;
   logic [CNT_BIT-1:0] i_total_cnt = '0;
   logic [CNT_BIT-1:0] i_chunk_cnt = '0;
   logic               o_idle;
   logic               o_busy;
   logic               o_done;
   logic [CNT_BIT-1:0] o_chunks_done;

   dm_run_scheduler_if #(.CNT_BIT(CNT_BIT), .AWIDTH(AWIDTH)) dm ();

   dm_run_scheduler #(.CNT_BIT(CNT_BIT), .AWIDTH(AWIDTH)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_run         (i_run),
      .i_total_cnt   (i_total_cnt),
      .i_chunk_cnt   (i_chunk_cnt),
      .o_idle        (o_idle),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_chunks_done (o_chunks_done),
      .dm            (dm)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Data mover model. Fast: idle drops right after a run, done pulses once.
   // Sticky: idle drop delayed 3 more cycles and done held until the next run
   // is actually taken, so a stale done sits on the bus while idle is still high.
   bit sticky = 1'b0;
   logic mv_idle, mv_done, mv_active;
   int   mv_cnt;
   int   drop;
   assign drop = sticky ? 4 : 1;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mv_idle   <= 1'b1;
         mv_done   <= 1'b0;
         mv_active <= 1'b0;
         mv_cnt    <= 0;
      end else if (dm.o_dm_run) begin
         mv_active <= 1'b1;
         mv_cnt    <= 1;
      end else if (mv_active) begin
         mv_cnt <= mv_cnt + 1;
         if (mv_cnt == drop) begin
            mv_idle <= 1'b0;
            mv_done <= 1'b0;
         end
         if (mv_cnt == drop + 3) begin
            mv_idle   <= 1'b1;
            mv_done   <= 1'b1;
            mv_active <= 1'b0;
         end
      end else if (!sticky) begin
         mv_done <= 1'b0;
      end
   end

   assign dm.i_dm_idle = mv_idle;
   assign dm.i_dm_done = mv_done;

   // Scoreboard
   run_t exp_q[$];
   int   done_q[$];
   int   n_tests = 0;
   int   n_fail = 0;
   bit   lat_check = 1'b0;
   int   start_cyc = 0;

   function automatic void check(string name, longint act, longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endfunction

   function automatic void push_run(int cnt, int base);
      run_t r;
      r.cnt  = cnt;
      r.base = base;
      exp_q.push_back(r);
   endfunction

   task automatic monitor();
      run_t e;
      int   d;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (dm.o_dm_run) begin
               check("run_while_mover_busy", longint'(mv_active), 0);
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_run: got count %0d base %0d, required no run",
                           dm.o_dm_num_cnt, dm.o_dm_base);
               end else begin
                  e = exp_q.pop_front();
                  check("run_count", longint'(dm.o_dm_num_cnt), e.cnt);
                  check("run_base", longint'(dm.o_dm_base), e.base);
               end
               if (lat_check) begin
                  lat_check = 1'b0;
                  check("start_to_run_latency", cyc - start_cyc, 2);
               end
            end
            if (o_done) begin
               if (done_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_done: got o_done=1, required 0");
               end else begin
                  d = done_q.pop_front();
                  check("chunks_done_at_done", longint'(o_chunks_done), d);
               end
            end
         end
      end
   endtask

   // Called at a negedge; returns just after the edge that samples i_run.
   task automatic run_job(input int total, input int chunk, input bit lat);
      i_total_cnt = CNT_BIT'(total);
      i_chunk_cnt = CNT_BIT'(chunk);
      i_run       = 1'b1;
      start_cyc   = cyc;
      lat_check   = lat;
      @(posedge clk);
      #1;
      i_run = 1'b0;
   endtask

   task automatic wait_done(output int waited);
      waited = -1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (o_done) begin
            waited = i;
            break;
         end
      end
      if (waited < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout: got no o_done in 1000 cycles, required a pulse");
      end
   endtask

   task automatic wait_runs(input int left);
      bit ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (exp_q.size() <= left) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL run_timeout: got %0d runs pending, required %0d", exp_q.size(), left);
      end
   endtask

   initial begin
      int w;
      fork
         monitor();
      join_none

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_idle", longint'(o_idle), 1);
      check("rst_busy", longint'(o_busy), 0);
      check("rst_done", longint'(o_done), 0);
      check("rst_run", longint'(dm.o_dm_run), 0);
      check("rst_num_cnt", longint'(dm.o_dm_num_cnt), 0);
      check("rst_base", longint'(dm.o_dm_base), 0);
      check("rst_chunks_done", longint'(o_chunks_done), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // 8192 in 2048-word chunks, mover always ready
      push_run(2048, 0);
      push_run(2048, 2048);
      push_run(2048, 4096);
      push_run(2048, 6144);
      done_q.push_back(4);
      run_job(8192, 2048, 1'b1);
      check("busy_after_start", longint'(o_busy), 1);
      wait_done(w);
      @(negedge clk);
      check("idle_after_job", longint'(o_idle), 1);

      // 5000 in 2048-word chunks: remainder chunk of 904
      push_run(2048, 0);
      push_run(2048, 2048);
      push_run(904, 4096);
      done_q.push_back(3);
      run_job(5000, 2048, 1'b1);
      wait_done(w);
      @(negedge clk);

      // Empty job: no runs, prompt done
      done_q.push_back(0);
      run_job(0, 2048, 1'b0);
      wait_done(w);
      check("zero_total_done_within_2", longint'(w <= 1), 1);
      @(negedge clk);

      // Zero chunk size: one run for the whole total
      push_run(100, 0);
      done_q.push_back(1);
      run_job(100, 0, 1'b1);
      wait_done(w);

      // Back-to-back: new job the cycle after o_done clears the chunk count
      push_run(2048, 0);
      push_run(952, 2048);
      done_q.push_back(2);
      @(negedge clk);
      run_job(3000, 2048, 1'b1);
      check("b2b_chunks_done_cleared", longint'(o_chunks_done), 0);
      check("b2b_busy", longint'(o_busy), 1);
      wait_done(w);
      @(negedge clk);

      // Sticky-done mover plus a stray i_run while waiting on the mover
      sticky = 1'b1;
      push_run(2048, 0);
      push_run(2048, 2048);
      push_run(2048, 4096);
      push_run(2048, 6144);
      done_q.push_back(4);
      run_job(8192, 2048, 1'b0);
      wait_runs(3);
      @(negedge clk);
      i_total_cnt = CNT_BIT'(100);
      i_chunk_cnt = '0;
      i_run       = 1'b1;
      @(negedge clk);
      i_run = 1'b0;
      wait_done(w);
      @(negedge clk);
      sticky = 1'b0;
      repeat (2) @(negedge clk);

      // Reset mid-job aborts and discards the job
      push_run(2048, 0);
      run_job(8192, 2048, 1'b0);
      wait_runs(0);
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midrst_idle", longint'(o_idle), 1);
      check("midrst_busy", longint'(o_busy), 0);
      check("midrst_run", longint'(dm.o_dm_run), 0);
      check("midrst_num_cnt", longint'(dm.o_dm_num_cnt), 0);
      check("midrst_base", longint'(dm.o_dm_base), 0);
      check("midrst_chunks_done", longint'(o_chunks_done), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      check("post_rst_idle", longint'(o_idle), 1);
      check("post_rst_busy", longint'(o_busy), 0);

      check("runs_outstanding", exp_q.size(), 0);
      check("dones_outstanding", done_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
